// File: rtl/cover_pkg.sv
// cover_pkg
//   Shared definitions for toggle-coverage producers.
//   COVER_TOTAL : size of the global cover space
//   IDX_W       : width of an emitted cover index
//   cover_idx_t : absolute cover index type
//   popcount()  : number of set bits in a vector of up to POP_MAX bits
package cover_pkg;

  localparam int COVER_TOTAL = 38253;
  localparam int IDX_W       = 64;
  localparam int POP_MAX     = 1024;
  localparam int POP_W       = 11;

  typedef logic [IDX_W-1:0] cover_idx_t;

  // Count set bits. Narrower vectors are zero-extended by the caller.
  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] vec);
    logic [POP_W-1:0] cnt;
    cnt = {POP_W{1'b0}};
    for (int i = 0; i < POP_MAX; i++) begin
      cnt = cnt + {{(POP_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// cover_prio_enc
//   Combinational lowest-set-bit encoder.
//   req    in  WIDTH  request vector
//   any    out 1      at least one request bit set
//   idx    out BIT_W  index of the lowest set bit (0 when none)
//   onehot out WIDTH  isolated lowest set bit (0 when none)
module cover_prio_enc #(
  parameter int WIDTH = 66,
  parameter int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             any,
  output logic [BIT_W-1:0] idx,
  output logic [WIDTH-1:0] onehot
);

  // Isolate the lowest set bit with the two's-complement trick, then encode it.
  always_comb begin
    any    = |req;
    onehot = req & (~req + WIDTH'(1'b1));
    idx    = {BIT_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      idx = idx | (onehot[i] ? BIT_W'(i) : {BIT_W{1'b0}});
    end
  end

endmodule

// File: rtl/toggle_cover_serializer_chk.sv
// toggle_cover_serializer_chk
//   Simulation-only protocol checker for the cover event stream.
//   gbl_clk, reset            : clock and synchronous active-low reset
//   out_valid, out_ready      : stream handshake
//   out_index                 : stream payload
module toggle_cover_serializer_chk
  import cover_pkg::*;
(
  input logic       gbl_clk,
  input logic       reset,
  input logic       out_valid,
  input logic       out_ready,
  input cover_idx_t out_index
);

  // A stalled event must stay presented, unchanged, until accepted.
  hold_stable_a: assert property (
    @(posedge gbl_clk) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_index))
  );

endmodule

// File: rtl/toggle_cover_serializer.sv
// toggle_cover_serializer
//   Records the first hit of each toggle point in a sticky bitmap and streams
//   each newly hit point once per arm period as an absolute cover index.
//   gbl_clk    in   1        clock
//   reset      in   1        synchronous, active-low reset
//   valid      in   WIDTH    per-bit toggle-hit strobe
//   rearm      in   1        pulse: forget all hits, re-enable reporting
//   out_valid  out  1        out_index holds an unsent event
//   out_ready  in   1        sink accepts the event this cycle
//   out_index  out  IDX_W    COVER_INDEX + bit
//   hit_count  out  CNT_W    distinct bits hit since reset/rearm
//   all_hit    out  1        hit_count == WIDTH
module toggle_cover_serializer
  import cover_pkg::*;
#(
  parameter int          WIDTH       = 66,
  parameter int unsigned COVER_INDEX = 0
) (
  input  logic                         gbl_clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         rearm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output cover_idx_t                   out_index,
  output logic [$clog2(WIDTH+1)-1:0]   hit_count,
  output logic                         all_hit
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 1) begin : g_width_chk
    $fatal(1, "toggle_cover_serializer: WIDTH must be >= 1");
  end
  if (longint'(COVER_INDEX) + longint'(WIDTH) > longint'(COVER_TOTAL)) begin : g_range_chk
    $fatal(1, "toggle_cover_serializer: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] seen_r;
  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] new_s;
  logic [WIDTH-1:0] grant_s;
  logic [WIDTH-1:0] onehot_s;
  logic [BIT_W-1:0] enc_idx_s;
  logic             any_s;
  logic             slot_free_s;
  logic             fire_s;
  logic [CNT_W-1:0] hit_next_s;

  cover_prio_enc #(
    .WIDTH (WIDTH),
    .BIT_W (BIT_W)
  ) u_prio_enc (
    .req    (pending_r),
    .any    (any_s),
    .idx    (enc_idx_s),
    .onehot (onehot_s)
  );

  // New hits, grant decision and next hit count. Granting is suppressed
  // during rearm so nothing from the forgotten pending set escapes.
  always_comb begin
    new_s       = valid & ~seen_r;
    slot_free_s = !out_valid || out_ready;
    fire_s      = any_s && slot_free_s && !rearm;
    grant_s     = fire_s ? onehot_s : {WIDTH{1'b0}};
    hit_next_s  = hit_count + CNT_W'(popcount(POP_MAX'(new_s)));
  end

  // Hit tracking: sticky seen map, pending queue and counters.
  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      seen_r    <= {WIDTH{1'b0}};
      pending_r <= {WIDTH{1'b0}};
      hit_count <= {CNT_W{1'b0}};
      all_hit   <= 1'b0;
    end else if (rearm) begin
      seen_r    <= {WIDTH{1'b0}};
      pending_r <= {WIDTH{1'b0}};
      hit_count <= {CNT_W{1'b0}};
      all_hit   <= 1'b0;
    end else begin
      seen_r    <= seen_r | new_s;
      pending_r <= (pending_r | new_s) & ~grant_s;
      hit_count <= hit_next_s;
      all_hit   <= (hit_next_s == CNT_W'(WIDTH));
    end
  end

  // Output register: load on grant, drop when drained, hold while stalled.
  // Rearm does not touch it so an in-flight event completes its handshake.
  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_index <= {IDX_W{1'b0}};
    end else if (fire_s) begin
      out_valid <= 1'b1;
      out_index <= cover_idx_t'(COVER_INDEX) + cover_idx_t'(enc_idx_s);
    end else if (slot_free_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifndef SYNTHESIS
  toggle_cover_serializer_chk u_chk (
    .gbl_clk   (gbl_clk),
    .reset     (reset),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index)
  );
`endif

endmodule

// File: tb/tb_toggle_cover_serializer.sv
// tb_toggle_cover_serializer
//   Directed stimulus with a scoreboard queue of expected cover indices; a
//   monitor process pops and compares on every accepted transfer.
module tb_toggle_cover_serializer;

  localparam int W  = 66;
  localparam int CI = 100;

  logic          gbl_clk;
  logic          reset;
  logic [W-1:0]  valid;
  logic          rearm;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_index;
  logic [6:0]    hit_count;
  logic          all_hit;

  int checks = 0;
  int errors = 0;
  longint unsigned exp_q[$];

  toggle_cover_serializer #(.WIDTH(W), .COVER_INDEX(CI)) dut (
    .gbl_clk   (gbl_clk),
    .reset     (reset),
    .valid     (valid),
    .rearm     (rearm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .hit_count (hit_count),
    .all_hit   (all_hit)
  );

  initial gbl_clk = 1'b0;
  always #5 gbl_clk = ~gbl_clk;

  task automatic tick();
    @(posedge gbl_clk);
    #1;
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    longint unsigned e;
    forever begin
      @(negedge gbl_clk);
      if (reset && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stray_transfer actual=%0d expected=none", out_index);
        end else begin
          e = exp_q.pop_front();
          if (out_index !== e) begin
            errors++;
            $display("FAIL stream_index actual=%0d expected=%0d", out_index, e);
          end
        end
      end
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL %s_drain actual=%0d_left expected=0_left", name, exp_q.size());
    end
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none

    // 1 Reset with valid all-ones.
    reset = 1'b0; valid = '1; rearm = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_hit_count", hit_count, 0);
    check("reset_all_hit", all_hit, 0);
    reset = 1'b1; valid = '0;
    tick();
    check("post_reset_out_valid", out_valid, 0);

    // 2 Single hit, latency N+2, then dedup.
    valid[5] = 1'b1; exp_q.push_back(105);
    tick();
    valid = '0;
    check("lat_n1_out_valid", out_valid, 0);
    tick();
    check("lat_n2_out_valid", out_valid, 1);
    check("lat_n2_out_index", out_index, 105);
    drain("single", 10);
    valid[5] = 1'b1;
    tick();
    valid = '0;
    repeat (4) tick();
    check("dedup_out_valid", out_valid, 0);
    check("dedup_hit_count", hit_count, 1);

    // 3 Burst of 65,0,64 emitted ascending on consecutive cycles.
    pulse_rearm();
    valid[65] = 1'b1; valid[0] = 1'b1; valid[64] = 1'b1;
    exp_q.push_back(100); exp_q.push_back(164); exp_q.push_back(165);
    tick();
    valid = '0;
    tick();
    check("burst_c0_index", out_valid ? out_index : 0, 100);
    tick();
    check("burst_c1_index", out_valid ? out_index : 0, 164);
    tick();
    check("burst_c2_index", out_valid ? out_index : 0, 165);
    drain("burst", 10);
    check("burst_hit_count", hit_count, 3);

    // 4 Backpressure on bits 1,2.
    out_ready = 1'b0;
    valid[1] = 1'b1; valid[2] = 1'b1;
    exp_q.push_back(101); exp_q.push_back(102);
    tick();
    valid = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_index", out_index, 101);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_second_index", out_valid ? out_index : 0, 102);
    drain("backpressure", 10);
    check("bp_hit_count", hit_count, 5);

    // 5 Full coverage.
    pulse_rearm();
    valid = '1;
    for (int i = 0; i < W; i++) exp_q.push_back(longint'(CI + i));
    tick();
    valid = '0;
    check("full_hit_count", hit_count, 66);
    check("full_all_hit", all_hit, 1);
    drain("full", 100);
    check("full_all_hit_after_drain", all_hit, 1);

    // 6 Rearm while 101 is stalled in the output register.
    pulse_rearm();
    check("rearm_all_hit", all_hit, 0);
    out_ready = 1'b0;
    valid[1] = 1'b1; valid[2] = 1'b1; valid[3] = 1'b1; valid[4] = 1'b1;
    exp_q.push_back(101);
    tick();
    valid = '0;
    tick();
    check("mid_stall_index", out_index, 101);
    pulse_rearm();
    check("mid_rearm_hit_count", hit_count, 0);
    check("mid_rearm_out_valid", out_valid, 1);
    out_ready = 1'b1;
    drain("mid_rearm", 10);
    repeat (4) tick();
    valid[2] = 1'b1; exp_q.push_back(102);
    tick();
    valid = '0;
    drain("post_rearm", 10);
    check("post_rearm_hit_count", hit_count, 1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
